// File: rtl/axis_frame_sequencer_if.sv
// AXI4-Stream video link (tuser = start of frame, tlast = end of line)
// carrying one 10-bit pixel per beat, zero-extended to 16 bits.
interface axis_frame_sequencer_if;
  logic        tvalid;
  logic        tready;
  logic [15:0] tdata;
  logic        tuser;
  logic        tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_frame_sequencer.sv
// Sequences a raw pixel source into framed AXI4-Stream video with programmable
// frame count, horizontal/vertical blanking and full backpressure handling.
module axis_frame_sequencer #(
  parameter int HSIZE   = 1920,
  parameter int VSIZE   = 1080,
  parameter int H_BLANK = 3,
  parameter int V_BLANK = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic [10:0]                   num_frames_in,
  input  logic                          src_valid_in,
  input  logic [9:0]                    src_data_in,
  output logic                          src_ready_out,
  axis_frame_sequencer_if.master        m_axis,
  output logic                          busy_out,
  output logic                          frame_done_out,
  output logic [10:0]                   frame_cnt_out
);

  localparam int PW    = $clog2(HSIZE);
  localparam int LW    = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam int BMAX  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int H_END = (H_BLANK > 0) ? H_BLANK - 1 : 0;
  localparam int V_END = (V_BLANK > 0) ? V_BLANK - 1 : 0;

  localparam logic [PW-1:0] PIX_LAST  = PW'(HSIZE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(VSIZE - 1);
  localparam logic [BW-1:0] H_LAST    = BW'(H_END);
  localparam logic [BW-1:0] V_LAST    = BW'(V_END);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  state_t         state_r, state_s, end_state_s;
  logic [PW-1:0]  pix_r, pix_s;
  logic [LW-1:0]  line_r, line_s;
  logic [BW-1:0]  blank_r, blank_s;
  logic [10:0]    num_frames_r;
  logic [10:0]    frame_cnt_r;
  logic [11:0]    cnt_inc_s;
  logic           stop_r;
  logic           frame_done_r;
  logic           frame_end_s;
  logic           last_frame_s;
  logic           start_acc_s;
  logic           accept_s;
  logic           tvalid_r;
  logic [15:0]    tdata_r;
  logic           tuser_r;
  logic           tlast_r;

  assign busy_out       = (state_r != IDLE) || tvalid_r;
  assign start_acc_s    = (state_r == IDLE) && start_in && !busy_out;
  assign src_ready_out  = (state_r == ACTIVE) && (!tvalid_r || m_axis.tready);
  assign accept_s       = src_ready_out && src_valid_in;

  // Stop request arriving on the frame-end cycle itself still counts.
  assign cnt_inc_s      = {1'b0, frame_cnt_r} + 12'd1;
  assign last_frame_s   = stop_r || stop_in ||
                          ((num_frames_r != 11'd0) && (cnt_inc_s == {1'b0, num_frames_r}));
  assign end_state_s    = last_frame_s ? IDLE : ACTIVE;

  assign m_axis.tvalid  = tvalid_r;
  assign m_axis.tdata   = tdata_r;
  assign m_axis.tuser   = tuser_r;
  assign m_axis.tlast   = tlast_r;
  assign frame_done_out = frame_done_r;
  assign frame_cnt_out  = frame_cnt_r;

  // Next-state, pixel/line/blank counter update and frame-end detection.
  always_comb begin
    state_s     = state_r;
    pix_s       = pix_r;
    line_s      = line_r;
    blank_s     = blank_r;
    frame_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_acc_s) begin
          state_s = ACTIVE;
          pix_s   = '0;
          line_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (accept_s) begin
          if (pix_r == PIX_LAST) begin
            pix_s   = '0;
            blank_s = '0;
            if (line_r != LINE_LAST) begin
              line_s = line_r + 1'b1;
              if (H_BLANK != 0) state_s = HBLANK;
              else              state_s = ACTIVE;
            end else begin
              line_s = '0;
              if (V_BLANK != 0) begin
                state_s = VBLANK;
              end else begin
                frame_end_s = 1'b1;
                state_s     = end_state_s;
              end
            end
          end else begin
            pix_s = pix_r + 1'b1;
          end
        end else begin
          state_s = ACTIVE;
        end
      end
      HBLANK: begin
        if (blank_r == H_LAST) state_s = ACTIVE;
        else                   blank_s = blank_r + 1'b1;
      end
      VBLANK: begin
        if (blank_r == V_LAST) begin
          frame_end_s = 1'b1;
          state_s     = end_state_s;
        end else begin
          blank_s = blank_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and position counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
      pix_r   <= '0;
      line_r  <= '0;
      blank_r <= '0;
    end else begin
      state_r <= state_s;
      pix_r   <= pix_s;
      line_r  <= line_s;
      blank_r <= blank_s;
    end
  end

  // Run control: frame target, completed-frame count, sticky stop, done pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      num_frames_r <= 11'd0;
      frame_cnt_r  <= 11'd0;
      stop_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      if (start_acc_s) begin
        num_frames_r <= num_frames_in;
        frame_cnt_r  <= 11'd0;
        stop_r       <= 1'b0;
      end else begin
        if (frame_end_s) begin
          frame_cnt_r <= cnt_inc_s[11] ? 11'h7FF : cnt_inc_s[10:0];
        end
        if (frame_end_s && last_frame_s) begin
          stop_r <= 1'b0;
        end else if ((state_r != IDLE) && stop_in) begin
          stop_r <= 1'b1;
        end
      end
    end
  end

  // Output beat register; holds its contents while stalled, even once IDLE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tvalid_r <= 1'b0;
      tdata_r  <= 16'd0;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
    end else if (accept_s) begin
      tvalid_r <= 1'b1;
      tdata_r  <= {6'd0, src_data_in};
      tuser_r  <= (pix_r == '0) && (line_r == '0);
      tlast_r  <= (pix_r == PIX_LAST);
    end else if (m_axis.tready) begin
      tvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Scoreboard bench for axis_frame_sequencer on a 4x2 frame with 2/3-cycle blanking:
// accepted source pixels queue their expected beat, a monitor checks the stream.
module tb_axis_frame_sequencer;
  localparam int HS = 4, VS = 2, HB = 2, VB = 3, FRAME = HS * VS;

  typedef struct packed {
    logic [15:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, src_valid, src_ready, busy, frame_done;
  logic [10:0] num_frames, frame_cnt;
  logic [9:0]  src_data;

  axis_frame_sequencer_if axis ();

  axis_frame_sequencer #(.HSIZE(HS), .VSIZE(VS), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .stop_in(stop),
    .num_frames_in(num_frames), .src_valid_in(src_valid), .src_data_in(src_data),
    .src_ready_out(src_ready), .m_axis(axis), .busy_out(busy),
    .frame_done_out(frame_done), .frame_cnt_out(frame_cnt)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_tests = 0, n_fail = 0;
  int    epoch = 0, src_epoch = 0, beat_cnt = 0, done_cnt = 0;
  int    idx = 1, cyc = 0, last_acc = 0;
  logic  src_en = 1'b0, alt_mode = 1'b0, check_gap = 1'b0, phase = 1'b0, src_acc;
  logic  stall_prev = 1'b0, done_prev = 1'b0;
  beat_t held, got, exp_b;

  assign src_data = 10'(idx);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel p (1-based) of a run: tuser on the first pixel of each frame, tlast every HS pixels.
  function automatic beat_t make_beat(int p);
    beat_t b;
    b.data = {6'd0, 10'(p)};
    b.user = ((p - 1) % FRAME) == 0;
    b.last = (p % HS) == 0;
    return b;
  endfunction

  // Source model: presents pixel idx, pushes expectation on each handshake.
  always begin
    @(negedge clk);
    src_acc = src_valid && src_ready;
    if (src_acc) begin
      exp_q.push_back(make_beat(idx));
      if (check_gap && (idx % HS == 1) && (idx > 1)) check("line_gap", cyc - last_acc - 1, HB);
      last_acc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (src_acc) idx++;
    if (src_epoch != epoch) begin
      src_epoch = epoch;
      idx = 1;
      exp_q.delete();
    end
    phase = ~phase;
    src_valid = src_en && (!alt_mode || phase);
  end

  // Stream monitor: beat ordering/content and stall stability.
  always begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (stall_prev) begin
        check("hold_tvalid", axis.tvalid, 1);
        check("hold_tdata", axis.tdata, held.data);
        check("hold_tuser", axis.tuser, held.user);
        check("hold_tlast", axis.tlast, held.last);
      end
      if (axis.tvalid && !axis.tready) begin
        check("stall_src_ready", src_ready, 0);
        held = '{data: axis.tdata, user: axis.tuser, last: axis.tlast};
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (axis.tvalid && axis.tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          got   = '{data: axis.tdata, user: axis.tuser, last: axis.tlast};
          check("beat", got, exp_b);
        end
        beat_cnt++;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Frame-done pulse counter; the pulse must be a single cycle.
  always begin
    @(negedge clk);
    if (frame_done) begin
      check("done_single_cycle", done_prev, 0);
      done_cnt++;
    end
    done_prev = frame_done;
  end

  task automatic do_start(logic [10:0] nf);
    @(posedge clk); #1;
    num_frames = nf;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max_cyc);
    check("idle_reached", busy, 0);
  endtask

  task automatic end_checks(string tag, int frames, int done_base, int beat_base);
    check({tag, "_frame_cnt"}, frame_cnt, frames);
    check({tag, "_done_pulses"}, done_cnt - done_base, frames);
    check({tag, "_beats"}, beat_cnt - beat_base, frames * FRAME);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int db, bb, n;
    logic found;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_frames = 11'd0; axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_tdata", axis.tdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    src_en = 1'b1;

    // One frame, full throughput, line gap measured.
    db = done_cnt; bb = beat_cnt; epoch++; check_gap = 1'b1;
    do_start(11'd1);
    wait_idle(100);
    check_gap = 1'b0;
    end_checks("t1", 1, db, bb);

    // Downstream stall of 5 cycles on beat 2.
    repeat (2) @(posedge clk);
    db = done_cnt; bb = beat_cnt; epoch++;
    do_start(11'd1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      found = axis.tvalid && (axis.tdata == 16'd2);
    end
    check("t2_beat2_seen", found, 1);
    axis.tready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    axis.tready = 1'b1;
    wait_idle(100);
    end_checks("t2", 1, db, bb);

    // Source valid alternating.
    repeat (2) @(posedge clk);
    db = done_cnt; bb = beat_cnt; epoch++; alt_mode = 1'b1;
    do_start(11'd1);
    wait_idle(150);
    alt_mode = 1'b0;
    end_checks("t3", 1, db, bb);

    // Continuous run stopped during frame 2.
    repeat (2) @(posedge clk);
    db = done_cnt; bb = beat_cnt; epoch++;
    do_start(11'd0);
    n = 0;
    while (frame_cnt != 11'd1 && n < 100) begin @(negedge clk); n++; end
    check("t4_frame1_done", frame_cnt, 1);
    repeat (3) begin @(posedge clk); #1; end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle(100);
    end_checks("t4", 2, db, bb);
    repeat (10) begin @(negedge clk); check("t4_no_src_ready", src_ready, 0); end

    // Three frames, start retriggered while busy.
    db = done_cnt; bb = beat_cnt; epoch++;
    do_start(11'd3);
    repeat (3) begin
      repeat (8) begin @(posedge clk); #1; end
      num_frames = 11'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle(200);
    end_checks("t5", 3, db, bb);

    // Asynchronous reset mid-line, then a clean restart.
    repeat (2) @(posedge clk);
    bb = beat_cnt; epoch++;
    do_start(11'd1);
    n = 0;
    do begin @(negedge clk); #2; n++; end while ((beat_cnt - bb) < 2 && n < 50);
    check("t6_two_beats", beat_cnt - bb, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", axis.tvalid, 0);
    check("t6_rst_tlast", axis.tlast, 0);
    check("t6_rst_src_ready", src_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_cnt", frame_cnt, 0);
    epoch++;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); check("t6_idle_src_ready", src_ready, 0); end
    db = done_cnt; bb = beat_cnt;
    do_start(11'd1);
    wait_idle(100);
    end_checks("t6", 1, db, bb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/axis_frame_sequencer.md
# axis_frame_sequencer

Controller that sequences a raw 10-bit pixel source into a framed AXI4-Stream video stream (tuser = start of frame, tlast = end of line) with programmable frame count, horizontal/vertical blanking and full backpressure handling. It sits between the test pixel source/FIFO and downstream video IP. It owns all frame/line/pixel counting, so the source only supplies data on request.

## Interface
- HSIZE, 1920: active pixels per line (≥2)
- VSIZE, 1080: active lines per frame (≥1)
- H_BLANK, 3: idle cycles inserted after each line except the last (0 = none)
- V_BLANK, 16: idle cycles inserted after the last line of a frame (0 = none)

- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- start_in  input  1  single-cycle start request; ignored while busy_out=1
- stop_in  input  1  request to stop; sticky until honoured at the next frame boundary
- num_frames_in  input  11  frames to emit; sampled on accepted start; 0 = continuous
- src_valid_in  input  1  source pixel valid
- src_data_in  input  10  source pixel
- src_ready_out  output  1  source pixel accepted when src_valid_in && src_ready_out
- m_axis_tready_in  input  1  downstream ready
- m_axis_tvalid_out  output  1  stream valid
- m_axis_tdata_out  output  16  {6'b0, pixel}
- m_axis_tuser_out  output  1  high on pixel (0,0) of each frame
- m_axis_tlast_out  output  1  high on pixel HSIZE-1 of each line
- busy_out  output  1  state≠IDLE or m_axis_tvalid_out=1
- frame_done_out  output  1  one-cycle pulse per completed frame
- frame_cnt_out  output  11  frames completed since last accepted start

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: start_in && !busy_out → ACTIVE; load num_frames, clear pixel/line counters, frame_cnt_out, stop flag.
- ACTIVE: src_ready_out = (!m_axis_tvalid_out || m_axis_tready_in), combinational; 0 in all other states.
- On accept: output register loads src_data_in, tuser = (pix==0 && line==0), tlast = (pix==HSIZE-1); pix increments.
- Accept of pix==HSIZE-1: pix→0; if line<VSIZE-1, line+1 and → HBLANK (or stay ACTIVE if H_BLANK=0); else line→0 and → VBLANK (or frame-end directly if V_BLANK=0).
- HBLANK/VBLANK: blank counter runs H_BLANK/V_BLANK cycles regardless of tready; then exit.
- Frame end: frame_cnt_out+1, frame_done_out pulses. If stop flag set, or num_frames≠0 and new count==num_frames → IDLE; else → ACTIVE.
- stop_in sets sticky flag in any non-IDLE state; never truncates a frame.
- frame_cnt_out saturates at 2047; frame count compare uses the pre-saturation value.
- Output register: tvalid cleared when tready && no new accept in same cycle; tvalid/tdata/tuser/tlast held stable while tvalid && !tready, in any state incl. IDLE.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, stop flag 0.
- Latency: source accept at cycle N → beat on m_axis at N+1.
- Throughput: 1 pixel/cycle with tready=1, src_valid=1.
- Start accepted at N → src_ready_out may rise at N+1.
- Line gap with tready=1: exactly H_BLANK cycles of src_ready_out=0 between tlast accept and next accept.
- frame_done_out registered: high the cycle after the last VBLANK cycle (or after the final accept if V_BLANK=0); state transition same edge.
- Simultaneous stop_in and frame end: stop honoured for that frame end.
- start_in in the same cycle as return to IDLE: ignored (busy_out still 1).
- Reset mid-line: immediate abort, no partial tlast; restart needs new start_in.

## Test plan
- HSIZE=4, VSIZE=2, H_BLANK=2, V_BLANK=3, num_frames=1, tready=1, src data 1..8 → 8 beats, tuser on beat 1 only, tlast on data 4 and 8, 2-cycle src_ready gap between lines, one frame_done pulse, frame_cnt_out=1, busy_out low afterwards.
- Same config, tready low 5 cycles during beat 2 → tvalid/tdata=2 held stable, src_ready_out low, sequence 1..8 with no loss/duplication.
- src_valid_in alternating 1/0 → counters advance only on accepts; tlast still on 4th accepted pixel.
- num_frames=0, stop_in pulsed mid-frame 2 → frame 2 completes, frame_cnt_out=2, IDLE, no further src_ready.
- num_frames=3, start_in repeated while busy → ignored; exactly 3 frame_done pulses, 24 beats, frame_cnt_out=3.
- rst_n_in low mid-line of frame 1 → all outputs 0 immediately; new start_in gives a fresh frame beginning with tuser.
